sram_slot_arbiter: RTL and testbench

- Shares the single SRAM between the video fetcher and two bus requesters: CPU and aux (ramdisk/FDC buffer DMA).
- Time-slotted on the video_slice phase from the clock generator, in the 24 MHz domain.
- Video owns the SRAM while video_slice=1. Each video_slice=0 window carries at most one CPU or aux access, sequenced as a fixed 4-cycle SRAM cycle.

---
 rtl/sram_slot_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_sram_slot_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_slot_arbiter.sv
// Time-slotted SRAM arbiter: video owns the SRAM while video_slice=1, and each
// video_slice=0 window carries at most one 4-cycle CPU or aux access.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate CPU/aux grants instead of
// CPU priority with the STARVE_LIMIT anti-starvation rule.
module sram_slot_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk24,
  input  logic              reset_n,
  input  logic              video_slice,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ack,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [1:0]        owner
);

  typedef enum logic [2:0] {
    S_IDLE, S_VIDEO, S_ARB, S_SETUP, S_STROBE, S_DONE
  } state_t;

  localparam logic [1:0] OWN_VIDEO = 2'b00;
  localparam logic [1:0] OWN_CPU   = 2'b01;
  localparam logic [1:0] OWN_AUX   = 2'b10;
  localparam logic [1:0] OWN_IDLE  = 2'b11;

  state_t            state, state_d;
  logic              vs_q;
  logic              lat_aux, lat_aux_d;
  logic              lat_we, lat_we_d;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_d;
  logic [ADDR_W-1:0] sram_addr_d;
  logic [DATA_W-1:0] sram_dq_o_d, cpu_rdata_d, aux_rdata_d;
  logic              sram_dq_oe_d, sram_oe_n_d, sram_we_n_d;
  logic              cpu_ack_d, aux_ack_d;
  logic [1:0]        owner_d;
  logic              window_start;
  logic              grant_aux;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_aux, last_aux_d;
  assign grant_aux = aux_req && (!cpu_req || !last_aux);
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt, starve_d;
  assign grant_aux = aux_req && (!cpu_req || starve_cnt == LIMIT);
`endif

  // A window opens only on a 1->0 transition of the registered slice phase.
  assign window_start = vs_q && !video_slice;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d      = state;
    lat_aux_d    = lat_aux;
    lat_we_d     = lat_we;
    lat_wdata_d  = lat_wdata;
    sram_addr_d  = sram_addr;
    sram_dq_o_d  = sram_dq_o;
    sram_dq_oe_d = 1'b0;
    sram_oe_n_d  = 1'b1;
    sram_we_n_d  = 1'b1;
    owner_d      = owner;
    cpu_ack_d    = 1'b0;
    aux_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    aux_rdata_d  = aux_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    last_aux_d   = last_aux;
`else
    starve_d     = starve_cnt;
`endif

    if (video_slice) begin
      // Video preempts everything; an unfinished access is simply dropped and
      // re-arbitrated in a later window because the request is still held.
      state_d     = S_VIDEO;
      sram_addr_d = vid_addr;
      sram_oe_n_d = 1'b0;
      owner_d     = OWN_VIDEO;
    end else if (window_start) begin
      if (cpu_req || aux_req) begin
        state_d     = S_ARB;
        lat_aux_d   = grant_aux;
        lat_we_d    = grant_aux ? aux_we    : cpu_we;
        lat_wdata_d = grant_aux ? aux_wdata : cpu_wdata;
        sram_addr_d = grant_aux ? aux_addr  : cpu_addr;
        owner_d     = grant_aux ? OWN_AUX   : OWN_CPU;
      end else begin
        state_d = S_IDLE;
        owner_d = OWN_IDLE;
      end
    end else begin
      unique case (state)
        S_ARB: begin
          state_d = S_SETUP;
          if (lat_we) begin
            sram_dq_oe_d = 1'b1;
            sram_dq_o_d  = lat_wdata;
          end else begin
            sram_oe_n_d = 1'b0;
          end
        end
        S_SETUP: begin
          state_d = S_STROBE;
          if (lat_we) begin
            sram_dq_oe_d = 1'b1;
            sram_we_n_d  = 1'b0;
          end else begin
            sram_oe_n_d = 1'b0;
          end
        end
        S_STROBE: begin
          // Completion edge: read data is captured here and the ack registers.
          state_d   = S_DONE;
          cpu_ack_d = !lat_aux;
          aux_ack_d = lat_aux;
          if (lat_we)       sram_dq_oe_d = 1'b1;
          else if (lat_aux) aux_rdata_d  = sram_dq_i;
          else              cpu_rdata_d  = sram_dq_i;
`ifdef ARB_ROUND_ROBIN_EN
          last_aux_d = lat_aux;
`else
          if (!lat_aux && aux_req)
            starve_d = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
          else
            starve_d = '0;
`endif
        end
        default: begin
          state_d = S_IDLE;
          owner_d = OWN_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      vs_q       <= 1'b0;
      lat_aux    <= 1'b0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      owner      <= OWN_IDLE;
      cpu_ack    <= 1'b0;
      aux_ack    <= 1'b0;
      cpu_rdata  <= '0;
      aux_rdata  <= '0;
    end else begin
      state      <= state_d;
      vs_q       <= video_slice;
      lat_aux    <= lat_aux_d;
      lat_we     <= lat_we_d;
      lat_wdata  <= lat_wdata_d;
      sram_addr  <= sram_addr_d;
      sram_dq_o  <= sram_dq_o_d;
      sram_dq_oe <= sram_dq_oe_d;
      sram_oe_n  <= sram_oe_n_d;
      sram_we_n  <= sram_we_n_d;
      owner      <= owner_d;
      cpu_ack    <= cpu_ack_d;
      aux_ack    <= aux_ack_d;
      cpu_rdata  <= cpu_rdata_d;
      aux_rdata  <= aux_rdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Reset to "aux served last" so the first contested window goes to the CPU.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) last_aux <= 1'b1;
    else          last_aux <= last_aux_d;
  end
`else
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) starve_cnt <= '0;
    else          starve_cnt <= starve_d;
  end
`endif

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Self-checking bench for sram_slot_arbiter: directed steps plus randomized
// windows checked against a window-level behavioural model of the arbiter.
module tb_sram_slot_arbiter;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 8;
  localparam int STARVE_LIMIT = 4;

  logic              clk24       = 1'b0;
  logic              reset_n     = 1'b1;
  logic              video_slice = 1'b0;
  logic [ADDR_W-1:0] vid_addr    = '0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              aux_req = 1'b0, aux_we = 1'b0;
  logic [ADDR_W-1:0] aux_addr = '0;
  logic [DATA_W-1:0] aux_wdata = '0;
  logic              cpu_ack, aux_ack, sram_dq_oe, sram_oe_n, sram_we_n;
  logic [DATA_W-1:0] cpu_rdata, aux_rdata, sram_dq_o, sram_dq_i;
  logic [ADDR_W-1:0] sram_addr;
  logic [1:0]        owner;

  sram_slot_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk24(clk24), .reset_n(reset_n), .video_slice(video_slice), .vid_addr(vid_addr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .owner(owner)
  );

  always #5 clk24 = ~clk24;

  // Asynchronous SRAM: combinational read, write committed while we_n is low.
  logic [DATA_W-1:0] mem     [0:65535];
  logic [DATA_W-1:0] ref_mem [0:65535];
  assign sram_dq_i = mem[sram_addr];
  always @(posedge clk24) if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;

  int checks = 0;
  int errors = 0;

  // Reference model state, tracked per window.
  int                m_starve   = 0;
  bit                m_last_aux = 1'b1;
  logic [DATA_W-1:0] exp_cpu_rdata = '0;
  logic [DATA_W-1:0] exp_aux_rdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  // Window winner from the arbitration rules: 0 none, 1 CPU, 2 aux.
  function automatic int pick();
    if (!cpu_req && !aux_req) return 0;
    if (!cpu_req) return 2;
    if (!aux_req) return 1;
`ifdef ARB_ROUND_ROBIN_EN
    return m_last_aux ? 1 : 2;
`else
    return (m_starve == STARVE_LIMIT) ? 2 : 1;
`endif
  endfunction

  task automatic video_phase(input int n);
    video_slice = 1'b1;
    for (int i = 0; i < n; i++) begin
      vid_addr = 16'($urandom);
      tick();
      check("video_addr", 32'(sram_addr), 32'(vid_addr));
      check("video_bus", 32'({owner, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, aux_ack}),
            32'({2'b00, 1'b0, 1'b1, 1'b0, 2'b00}));
    end
  endtask

  task automatic new_requests(input int pct);
    if (!cpu_req && $urandom_range(99) < pct) begin
      cpu_req   = 1'b1;
      cpu_we    = 1'($urandom);
      cpu_addr  = 16'h0200 + 16'($urandom_range(15));
      cpu_wdata = 8'($urandom);
    end
    if (!aux_req && $urandom_range(99) < pct) begin
      aux_req   = 1'b1;
      aux_we    = 1'($urandom);
      aux_addr  = 16'h0200 + 16'($urandom_range(15));
      aux_wdata = 8'($urandom);
    end
  endtask

  // One arbitration window; abort_at in 0..2 raises video_slice after that cycle.
  task automatic run_window(input int abort_at, output int winner);
    int                w;
    bit                we, aborted;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    w       = pick();
    we      = (w == 1) ? cpu_we : aux_we;
    a       = (w == 1) ? cpu_addr : aux_addr;
    wd      = (w == 1) ? cpu_wdata : aux_wdata;
    winner  = 0;
    aborted = 1'b0;
    video_slice = 1'b0;
    for (int i = 0; i < 4 && !aborted; i++) begin
      tick();
      check("win_owner", 32'(owner), (w == 0) ? 32'd3 : 32'(w));
      if (w == 0) begin
        check("idle_bus", 32'({sram_oe_n, sram_we_n, sram_dq_oe}), 32'(3'b110));
      end else begin
        check("win_addr", 32'(sram_addr), 32'(a));
        check("win_we_n", 32'(sram_we_n), 32'(!(we && i == 2)));
        check("win_dq_oe", 32'(sram_dq_oe), 32'(we && i >= 1));
        if (we && i >= 1) check("win_dq_o", 32'(sram_dq_o), 32'(wd));
        if (i == 1 || i == 2) check("win_oe_n", 32'(sram_oe_n), 32'(we));
      end
      check("win_acks", 32'({cpu_ack, aux_ack}), 32'({i == 3 && w == 1, i == 3 && w == 2}));
      if (abort_at == i) begin
        video_slice = 1'b1;
        vid_addr    = 16'($urandom);
        tick();
        check("abort_bus", 32'({sram_we_n, sram_dq_oe, cpu_ack, aux_ack, owner}),
              32'({1'b1, 1'b0, 2'b00, 2'b00}));
        aborted = 1'b1;
      end
    end
    if (!aborted && w != 0) begin
      winner = w;
      if (we) ref_mem[a] = wd;
      else if (w == 1) exp_cpu_rdata = ref_mem[a];
      else exp_aux_rdata = ref_mem[a];
`ifdef ARB_ROUND_ROBIN_EN
      m_last_aux = (w == 2);
`else
      if (w == 1 && aux_req) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
      else m_starve = 0;
`endif
      if (w == 1) cpu_req = 1'b0;
      else aux_req = 1'b0;
    end
    if (!aborted) begin
      check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));
      check("aux_rdata", 32'(aux_rdata), 32'(exp_aux_rdata));
    end
  endtask

  int w;
`ifdef ARB_ROUND_ROBIN_EN
  int order_exp [10] = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
`else
  int order_exp [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i ^ (i >> 8) ^ 32'h3C);
      ref_mem[i] = mem[i];
    end

    // Reset values, taken without a clock edge and held across edges.
    #2 reset_n = 1'b0;
    #1;
    check("rst_bus", 32'({owner, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, aux_ack}),
          32'({2'b11, 1'b1, 1'b1, 1'b0, 2'b00}));
    check("rst_addr_dq", 32'({sram_addr, sram_dq_o}), 32'd0);
    check("rst_rdata", 32'({cpu_rdata, aux_rdata}), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle", 32'({owner, cpu_ack, aux_ack}), 32'({2'b11, 2'b00}));
    end

    // CPU read of 0x1234.
    mem[16'h1234] = 8'h5A;
    ref_mem[16'h1234] = 8'h5A;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    video_phase(4);
    run_window(-1, w);
    check("t_read_winner", 32'(w), 32'd1);
    check("t_read_rdata", 32'(cpu_rdata), 32'h5A);

    // CPU write 0xA5 to 0x0100.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'hA5;
    video_phase(4);
    run_window(-1, w);
    check("t_write_winner", 32'(w), 32'd1);
    check("t_write_mem", 32'(mem[16'h0100]), 32'hA5);

    // Aux write aborted in W2, then completed in the next window.
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h0101; aux_wdata = 8'h3C;
    video_phase(4);
    run_window(2, w);
    check("t_abort_noack", 32'(w), 32'd0);
    video_phase(4);
    run_window(-1, w);
    check("t_abort_retry", 32'(w), 32'd2);
    check("t_abort_mem", 32'(mem[16'h0101]), 32'h3C);

    // Reset pulsed during STROBE of a CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0102; cpu_wdata = 8'h77;
    video_phase(4);
    video_slice = 1'b0;
    tick(); tick(); tick();
    check("t_rst_strobe_we_n", 32'(sram_we_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("t_rst_async_bus", 32'({owner, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, aux_ack}),
          32'({2'b11, 1'b1, 1'b1, 1'b0, 2'b00}));
    check("t_rst_async_rdata", 32'({cpu_rdata, aux_rdata}), 32'd0);
    m_starve = 0; m_last_aux = 1'b1; exp_cpu_rdata = '0; exp_aux_rdata = '0;
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t_rst_no_ack", 32'({owner, cpu_ack, aux_ack}), 32'({2'b11, 2'b00}));
    end

    // Both requesters held continuously: grant order.
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0205;
    for (int k = 0; k < 10; k++) begin
      video_phase(4);
      run_window(-1, w);
      check($sformatf("grant_order_%0d", k), 32'(w), 32'(order_exp[k]));
      if (k < 9) new_requests(100);
    end
    for (int k = 0; k < 3 && (cpu_req || aux_req); k++) begin
      video_phase(4);
      run_window(-1, w);
    end
    check("drain_done", 32'({cpu_req, aux_req}), 32'd0);

    // No requests for 10 windows.
    for (int k = 0; k < 10; k++) begin
      video_phase(4);
      run_window(-1, w);
      check("idle_window", 32'(w), 32'd0);
    end

    // Randomized windows with occasional aborts.
    for (int k = 0; k < 40; k++) begin
      new_requests(60);
      video_phase($urandom_range(1, 4));
      run_window(($urandom_range(5) == 0) ? int'($urandom_range(2)) : -1, w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
